// File: rtl/reg_scoreboard_pkg.sv
// rtl/reg_scoreboard_pkg.sv - shared instruction types for the register scoreboard
//
// Purpose: register index type, stall-cause encoding and a small hazard helper
// shared by the scoreboard top and its per-register counter.
// Ports: none (package).
package reg_scoreboard_pkg;

  localparam int NUM_REGS = 32;

  typedef logic [4:0] reg_idx_t;

  typedef enum logic [1:0] {
    STALL_NONE  = 2'b00,
    STALL_RAW   = 2'b01,
    STALL_SAT   = 2'b10,
    STALL_FLUSH = 2'b11
  } stall_cause_t;

  // A source only blocks issue when it is really read, is not x0, and its
  // youngest pending producer cannot forward (load / CSR).
  function automatic logic src_hazard(input logic     use_src,
                                      input reg_idx_t idx,
                                      input logic     busy,
                                      input logic     late);
    return use_src && (idx != '0) && busy && late;
  endfunction

endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// rtl/reg_scoreboard_sb_counter.sv - pending-writer counter and late flag for one register
//
// Purpose: tracks how many writers of one architectural register are in
// flight and whether the youngest of them produces a non-forwardable result.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   flush         discard all pending writers at the next edge
//   inc           an issue targeting this register fires
//   dec           a writeback of this register retires
//   inc_late      iss_late of the issuing instruction
//   cnt           pending writer count
//   late          youngest pending writer is late
//   underflow     writeback seen while nothing is pending (combinational)
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             inc,
  input  logic             dec,
  input  logic             inc_late,
  output logic [CNT_W-1:0] cnt,
  output logic             late,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_d;
  logic             late_d;

  assign underflow = dec && (cnt == '0);

  always_comb begin
    cnt_d  = cnt;
    late_d = late;
    if (flush) begin
      cnt_d  = '0;
      late_d = 1'b0;
    end else if (inc && dec) begin
      // One writer leaves, one enters: the count is unchanged but the new
      // writer is now the youngest, so its lateness wins.
      late_d = inc_late;
    end else if (inc) begin
      // The top withholds issue at saturation; the guard keeps the counter
      // from wrapping even if that ever changes.
      if (cnt != CNT_MAX) begin
        cnt_d = cnt + CNT_ONE;
      end
      late_d = inc_late;
    end else if (dec) begin
      if (cnt != '0) begin
        cnt_d = cnt - CNT_ONE;
      end
      if (cnt <= CNT_ONE) begin
        late_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      late <= 1'b0;
    end else begin
      cnt  <= cnt_d;
      late <= late_d;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - register scoreboard for in-order issue with late producers
//
// Purpose: holds issue while a used source waits on a non-forwardable
// producer, while the destination's pending counter is saturated, or during a
// pipeline flush. x0 is never tracked.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   iss_valid / iss_ready       issue handshake (fires on valid && ready)
//   iss_rs1, iss_rs2            source indices
//   iss_use_rs1, iss_use_rs2    source actually read
//   iss_rd, iss_write_reg       destination and whether it is written
//   iss_late                    result is not forwardable
//   wb_valid, wb_rd             retiring writer
//   flush                       discard all pending writers
//   busy_vec                    bit i set while register i has pending writers
//   stall_cause                 00 none, 01 RAW, 10 saturated, 11 flush
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iss_valid,
  output logic        iss_ready,
  input  logic [4:0]  iss_rs1,
  input  logic [4:0]  iss_rs2,
  input  logic        iss_use_rs1,
  input  logic        iss_use_rs2,
  input  logic [4:0]  iss_rd,
  input  logic        iss_write_reg,
  input  logic        iss_late,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        flush,
  output logic [31:0] busy_vec,
  output logic [1:0]  stall_cause
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_REGS-1:0][CNT_W-1:0] cnt_q;
  logic [NUM_REGS-1:0]            late_q;
  logic [NUM_REGS-1:0]            inc_vec;
  logic [NUM_REGS-1:0]            dec_vec;
  logic [NUM_REGS-1:0]            underflow_vec;
  logic                           err_underflow_q;

  reg_idx_t     rs1_idx;
  reg_idx_t     rs2_idx;
  reg_idx_t     rd_idx;
  logic         raw_hazard;
  logic         sat_hazard;
  logic         issue_fire;
  stall_cause_t cause;

  assign rs1_idx = iss_rs1;
  assign rs2_idx = iss_rs2;
  assign rd_idx  = iss_rd;

  // x0 slot is hard-wired idle.
  assign cnt_q[0]         = '0;
  assign late_q[0]        = 1'b0;
  assign inc_vec[0]       = 1'b0;
  assign dec_vec[0]       = 1'b0;
  assign underflow_vec[0] = 1'b0;

  genvar i;
  generate
    for (i = 1; i < NUM_REGS; i++) begin : g_reg
      assign inc_vec[i] = issue_fire && iss_write_reg && (rd_idx == 5'(i));
      assign dec_vec[i] = wb_valid && (wb_rd == 5'(i));

      sb_counter #(
        .CNT_W(CNT_W)
      ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .inc      (inc_vec[i]),
        .dec      (dec_vec[i]),
        .inc_late (iss_late),
        .cnt      (cnt_q[i]),
        .late     (late_q[i]),
        .underflow(underflow_vec[i])
      );
    end
  endgenerate

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_vec[r] = (cnt_q[r] != '0);
    end
  end

  // Hazards look only at registered state; a same-cycle writeback is not
  // bypassed, so the stall releases one cycle after the writeback edge.
  // rs1 == rs2 simply evaluates the same slot twice, which ORs to one hazard.
  assign raw_hazard = iss_valid &&
                      (src_hazard(iss_use_rs1, rs1_idx, busy_vec[rs1_idx], late_q[rs1_idx]) ||
                       src_hazard(iss_use_rs2, rs2_idx, busy_vec[rs2_idx], late_q[rs2_idx]));

  assign sat_hazard = iss_valid && iss_write_reg && (rd_idx != '0) &&
                      (cnt_q[rd_idx] == CNT_MAX);

  assign iss_ready  = !flush && !raw_hazard && !sat_hazard;
  assign issue_fire = iss_valid && iss_ready;

  always_comb begin
    cause = STALL_NONE;
    if (flush) begin
      cause = STALL_FLUSH;
    end else if (raw_hazard) begin
      cause = STALL_RAW;
    end else if (sat_hazard) begin
      cause = STALL_SAT;
    end
  end

  assign stall_cause = cause;

  // One-cycle pulse for a stray writeback; a flushed writeback is ignored
  // rather than flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_underflow_q <= 1'b0;
    end else begin
      err_underflow_q <= !flush && (|underflow_vec);
    end
  end

endmodule
